// File: rtl/phy_pkg.sv
// ---------------------------------------------------------------------------
// phy_pkg
// Types and constants shared by the QPSK receiver, the transmitter and the
// symbol deframer.
//   SYM_W             bits per QPSK symbol (one dibit)
//   CSUM_W            width of the frame checksum
//   DEF_PAYLOAD_BYTES default number of payload bytes per frame
//   sym_t             one received dibit
//   phase_t           where the deframer is inside a frame
//   csum_add          adds one payload byte into the running checksum
// ---------------------------------------------------------------------------
package phy_pkg;

  localparam int SYM_W             = 2;
  localparam int CSUM_W            = 6;
  localparam int DEF_PAYLOAD_BYTES = 15;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_PAYLOAD = 2'd1,
    PH_CSUM    = 2'd2
  } phase_t;

  // The checksum is the byte sum mod 2^CSUM_W, so only the low bits of each
  // byte can ever affect it.
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                 input logic [7:0]        data);
    return sum + data[CSUM_W-1:0];
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// ---------------------------------------------------------------------------
// commit_fifo
// Byte FIFO with a speculative write pointer. Writes land at wr_spec; they
// become visible to the reader only when i_commit copies wr_spec into
// wr_commit. i_rollback throws away everything written since the last commit.
// One slot is always kept free, so capacity is DEPTH-1 entries.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_wr_en        write i_wr_data at wr_spec (ignored when full)
//   i_wr_data      {last, byte}
//   i_commit       publish all speculative entries
//   i_rollback     discard all speculative entries
//   o_out_valid    a committed entry is available
//   i_out_ready    consumer takes the entry at the head
//   o_out_data     head entry, zero when nothing is committed
//   o_level        entries held, committed plus speculative
// ---------------------------------------------------------------------------
module commit_fifo #(
  parameter int DEPTH = 32,
  parameter int DW    = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_commit,
  input  logic                   i_rollback,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [DW-1:0]          o_out_data,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_spec;
  logic [PW-1:0] r_wr_commit;
  logic [PW-1:0] r_rd;

  logic [PW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd_fire;

  // Occupancy and handshake decode; pointers carry an extra wrap bit so
  // equal pointers always mean empty.
  always_comb begin
    w_level   = r_wr_spec - r_rd;
    w_full    = (w_level == PW'(DEPTH - 1));
    w_empty   = (r_rd == r_wr_commit);
    w_wr      = i_wr_en && !w_full && !i_rollback;
    w_rd_fire = !w_empty && i_out_ready;
  end

  assign o_level     = w_level;
  assign o_out_valid = !w_empty;
  // The head slot is never rewritten while it is unread, so the data holds
  // steady through a stall.
  assign o_out_data  = w_empty ? {DW{1'b0}} : r_mem[r_rd[AW-1:0]];

  // Storage array write.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_spec[AW-1:0]] <= i_wr_data;
    end
  end

  // Pointer update: rollback only rewinds wr_spec, never rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_spec   <= {PW{1'b0}};
      r_wr_commit <= {PW{1'b0}};
      r_rd        <= {PW{1'b0}};
    end else begin
      if (i_rollback) begin
        r_wr_spec <= r_wr_commit;
      end else if (w_wr) begin
        r_wr_spec <= r_wr_spec + PW'(1);
      end
      if (i_commit) begin
        r_wr_commit <= r_wr_spec;
      end
      if (w_rd_fire) begin
        r_rd <= r_rd + PW'(1);
      end
    end
  end

endmodule

// File: rtl/symbol_deframer.sv
// ---------------------------------------------------------------------------
// symbol_deframer
// Turns the QPSK receiver's dibit stream into checked bytes. A frame is
// 4*PAYLOAD_BYTES payload dibits (MSB-first bytes) followed by a 6-bit
// checksum in 3 dibits. Bytes go into a commit/rollback FIFO and are released
// only when the checksum matches and nothing overflowed.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     one dibit per strobe, no backpressure
//   in_data      dibit
//   out_valid    committed byte available
//   out_ready    consumer accepts on out_valid & out_ready
//   out_data     payload byte
//   out_last     final byte of a frame
//   frame_ok     1-cycle pulse, frame committed
//   frame_err    1-cycle pulse, frame discarded (checksum, gap or overflow)
//   overflow     sticky, a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module symbol_deframer
  import phy_pkg::*;
#(
  parameter int PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
  parameter int FIFO_DEPTH    = 32,
  parameter int GAP_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  sym_t       in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       overflow
);

  localparam int PAY_SYMS   = 4 * PAYLOAD_BYTES;
  localparam int FRAME_SYMS = PAY_SYMS + 3;
  localparam int CW         = $clog2(FRAME_SYMS + 1);
  localparam int GW         = $clog2(GAP_CYCLES + 1);
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]     r_sym_cnt;
  logic [GW-1:0]     r_idle;
  logic [5:0]        r_shift;
  logic [CSUM_W-1:0] r_sum;
  logic [CSUM_W-1:0] r_rx_csum;
  logic              r_frame_bad;
  logic              r_commit;
  logic              r_rollback;
  logic              r_frame_ok;
  logic              r_frame_err;
  logic              r_overflow;

  phase_t            w_phase;
  logic [7:0]        w_byte;
  logic [CSUM_W-1:0] w_rx_csum;
  logic              w_byte_done;
  logic              w_frame_end;
  logic              w_csum_match;
  logic              w_gap_abort;
  logic              w_full;
  logic              w_wr_en;
  logic [8:0]        w_wr_data;
  logic [8:0]        w_rd_data;
  logic [LW-1:0]     w_level;

  // Frame position of the next accepted symbol.
  always_comb begin
    if (r_sym_cnt == {CW{1'b0}}) begin
      w_phase = PH_IDLE;
    end else if (r_sym_cnt < CW'(PAY_SYMS)) begin
      w_phase = PH_PAYLOAD;
    end else begin
      w_phase = PH_CSUM;
    end
  end

  // Byte assembly, checksum compare and abort decode for the current symbol.
  always_comb begin
    w_byte       = {r_shift, in_data};
    w_rx_csum    = {r_rx_csum[CSUM_W-SYM_W-1:0], in_data};
    w_byte_done  = in_valid && (w_phase != PH_CSUM) && (r_sym_cnt[1:0] == 2'b11);
    w_frame_end  = in_valid && (r_sym_cnt == CW'(FRAME_SYMS - 1));
    w_csum_match = (w_rx_csum == r_sum);
    // Fires on the last of GAP_CYCLES idle cycles; the next cycle is a clean
    // frame start, so a symbol arriving there becomes symbol 0.
    w_gap_abort  = !in_valid && (w_phase != PH_IDLE) &&
                   (r_idle == GW'(GAP_CYCLES - 1));
    // One slot stays free so a full FIFO is distinguishable from an empty one.
    w_full       = (w_level == LW'(FIFO_DEPTH - 1));
    w_wr_en      = w_byte_done && !w_full;
    w_wr_data    = {(r_sym_cnt == CW'(PAY_SYMS - 1)), w_byte};
  end

  // Deframer state machine: symbol counter, packer, checksum and frame verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_cnt   <= {CW{1'b0}};
      r_idle      <= {GW{1'b0}};
      r_shift     <= 6'd0;
      r_sum       <= {CSUM_W{1'b0}};
      r_rx_csum   <= {CSUM_W{1'b0}};
      r_frame_bad <= 1'b0;
      r_commit    <= 1'b0;
      r_rollback  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_commit    <= 1'b0;
      r_rollback  <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      if (in_valid) begin
        r_idle <= {GW{1'b0}};
        if (w_frame_end) begin
          r_sym_cnt <= {CW{1'b0}};
          if (w_csum_match && !r_frame_bad) begin
            r_frame_ok <= 1'b1;
            r_commit   <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
            r_rollback  <= 1'b1;
          end
        end else begin
          r_sym_cnt <= r_sym_cnt + CW'(1);
        end
        if (w_phase == PH_CSUM) begin
          r_rx_csum <= w_rx_csum;
        end else begin
          r_shift <= {r_shift[3:0], in_data};
        end
        if (w_phase == PH_IDLE) begin
          r_sum       <= {CSUM_W{1'b0}};
          r_frame_bad <= 1'b0;
        end else if (w_byte_done) begin
          r_sum <= csum_add(r_sum, w_byte);
          if (w_full) begin
            // Byte is dropped; the frame keeps counting and fails at its end.
            r_frame_bad <= 1'b1;
            r_overflow  <= 1'b1;
          end
        end
      end else if (w_gap_abort) begin
        r_sym_cnt   <= {CW{1'b0}};
        r_idle      <= {GW{1'b0}};
        r_frame_err <= 1'b1;
        r_rollback  <= 1'b1;
      end else if (w_phase != PH_IDLE) begin
        r_idle <= r_idle + GW'(1);
      end else begin
        r_idle <= {GW{1'b0}};
      end
    end
  end

  commit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (9)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (w_wr_data),
    .i_commit    (r_commit),
    .i_rollback  (r_rollback),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_rd_data),
    .o_level     (w_level)
  );

  assign out_data  = w_rd_data[7:0];
  assign out_last  = w_rd_data[8];
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_symbol_deframer.sv
// ---------------------------------------------------------------------------
// tb_symbol_deframer
// Self-checking bench for symbol_deframer. The reference model predicts, per
// frame, whether it commits (byte sum mod 64 equals the sent checksum and the
// committed backlog leaves room for the frame) and queues the expected
// {last,byte} words; a negedge monitor pops them on every handshake.
// ---------------------------------------------------------------------------
module tb_symbol_deframer;

  localparam int PB    = 15;
  localparam int DEPTH = 32;
  localparam int GAP   = 64;
  localparam int FS    = 4 * PB + 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic [1:0] in_data   = 2'b00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  symbol_deframer #(
    .PAYLOAD_BYTES (PB),
    .FIFO_DEPTH    (DEPTH),
    .GAP_CYCLES    (GAP)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int         n_vec    = 0;
  int         n_err    = 0;
  int         n_ok     = 0;
  int         n_ferr   = 0;
  int         n_bytes  = 0;
  int         n_last   = 0;
  int         exp_ok   = 0;
  int         exp_ferr = 0;
  int         ready_mode = 1;   // 0 low, 1 high, 2 random
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // out_ready driver, changes just after the active edge
  always @(posedge clk) begin
    #1;
    if (ready_mode == 2) out_ready = ($urandom_range(0, 1) == 1);
    else                 out_ready = (ready_mode == 1);
  end

  // output monitor: pulses, handshakes against the scoreboard, stall stability
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = 9'h000;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_ok)  n_ok++;
      if (frame_err) n_ferr++;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_word", 32'({out_last, out_data}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_valid), 32'd0);
        end else begin
          check("byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
          n_bytes++;
          if (out_last) n_last++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  function automatic logic [5:0] good_csum(input logic [7:0] pl[PB]);
    int s = 0;
    foreach (pl[i]) s += int'(pl[i]);
    return 6'(s % 64);
  endfunction

  task automatic rand_payload(output logic [7:0] pl[PB]);
    for (int i = 0; i < PB; i++) pl[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_sym(input logic [1:0] d, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Sends the first nsym symbols of a frame; complete frames are predicted.
  task automatic send_frame(input logic [7:0] pl[PB], input logic [5:0] csum,
                            input int nsym, input int gap);
    int s = 0;
    logic [7:0] t;
    logic [5:0] c;
    if (nsym == FS) begin
      foreach (pl[i]) s += int'(pl[i]);
      if ((s % 64) == int'(csum) && (exp_q.size() + PB) <= (DEPTH - 1)) begin
        exp_ok++;
        for (int i = 0; i < PB; i++) exp_q.push_back({(i == PB - 1), pl[i]});
      end else begin
        exp_ferr++;
      end
    end
    for (int k = 0; k < nsym; k++) begin
      if (k < 4 * PB) begin
        t = pl[k / 4] >> (6 - 2 * (k % 4));
        send_sym(t[1:0], gap);
      end else begin
        c = csum >> (2 * (FS - 1 - k));
        send_sym(c[1:0], gap);
      end
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < 3000) begin @(posedge clk); #1; c++; end
    check(tag, 32'(exp_q.size()), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ok_cnt"}, 32'(n_ok), 32'(exp_ok));
    check({tag, "_err_cnt"}, 32'(n_ferr), 32'(exp_ferr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pl[PB];
    logic [5:0] cs;
    int         b0, l0, cyc;

    // reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'({out_last, out_data}), 32'd0);
    check("rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 1: good frame 0x00..0x0E, checksum 41
    for (int i = 0; i < PB; i++) pl[i] = 8'(i);
    b0 = n_bytes; l0 = n_last;
    send_frame(pl, good_csum(pl), FS, 0);
    check("t1_frame_ok_n1", 32'(frame_ok), 32'd1);
    @(posedge clk); #1;
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    drain("t1_drain");
    check_counts("t1");
    check("t1_bytes", 32'(n_bytes - b0), 32'd15);
    check("t1_last", 32'(n_last - l0), 32'd1);

    // 2: same payload, checksum off by one
    send_frame(pl, good_csum(pl) + 6'd1, FS, 0);
    for (int i = 0; i < 6; i++) begin
      check("t2_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    check_counts("t2");

    // 3: truncated frame, gap abort, then a good frame
    rand_payload(pl);
    send_frame(pl, good_csum(pl), 20, 0);
    exp_ferr++;
    cyc = 0;
    while (!frame_err && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("t3_gap_window", 32'(cyc >= GAP - 1 && cyc <= GAP + 2), 32'd1);
    b0 = n_bytes;
    rand_payload(pl);
    send_frame(pl, good_csum(pl), FS, 0);
    drain("t3_drain");
    check_counts("t3");
    check("t3_bytes", 32'(n_bytes - b0), 32'd15);

    // 4: consumer stalled, three frames back-to-back
    ready_mode = 0;
    repeat (2) begin @(posedge clk); #1; end
    b0 = n_bytes; l0 = n_last;
    for (int f = 0; f < 3; f++) begin
      rand_payload(pl);
      send_frame(pl, good_csum(pl), FS, 0);
    end
    repeat (4) begin @(posedge clk); #1; end
    check("t4_overflow", 32'(overflow), 32'd1);
    check_counts("t4");
    ready_mode = 1;
    drain("t4_drain");
    check("t4_bytes", 32'(n_bytes - b0), 32'd30);
    check("t4_last", 32'(n_last - l0), 32'd2);

    // 5: asynchronous reset in the middle of a frame
    ready_mode = 0;
    rand_payload(pl);
    send_frame(pl, good_csum(pl), FS, 0);
    rand_payload(pl);
    send_frame(pl, good_csum(pl), 30, 0);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_data", 32'({out_last, out_data}), 32'd0);
    check("t5_async_pulses", 32'({frame_ok, frame_err}), 32'd0);
    check("t5_async_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    ready_mode = 1;
    b0 = n_bytes;
    rand_payload(pl);
    send_frame(pl, good_csum(pl), FS, 0);
    drain("t5_drain");
    check_counts("t5");
    check("t5_bytes", 32'(n_bytes - b0), 32'd15);

    // 6: random ready, ten frames, one symbol every 8 clocks
    ready_mode = 2;
    b0 = n_bytes; l0 = n_last;
    for (int f = 0; f < 10; f++) begin
      rand_payload(pl);
      send_frame(pl, good_csum(pl), FS, 7);
    end
    drain("t6_drain");
    check_counts("t6");
    check("t6_bytes", 32'(n_bytes - b0), 32'd150);
    check("t6_last", 32'(n_last - l0), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
